bus_reg_bank: RTL

//  Register bank that sits on the byte bus and consumes and produces bus traffic.
//  It holds NREG byte registers and executes one transfer command at a time:
//   - LOAD:  external byte -> register
//   - STORE: register -> external output
//   - MOVE:  register -> register

---
 rtl/bus_pkg.sv | 21 ++
 rtl/bus_reg8.sv | 22 ++
 rtl/bus_reg_bank.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared encodings for the byte-bus register bank.
package bus_pkg;

   localparam int DEF_DATA_W = 8;

   // Command opcodes as they appear on cmd_op.
   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10,
      OP_MOVE  = 2'b11
   } op_e;

   // Transfer sequencer states.
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_WRITE = 2'b10
   } state_e;

endpackage

// File: rtl/bus_reg8.sv
// One bank register: loads d_i when we_i is high, clears asynchronously.
module bus_reg8 #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);

   logic [DATA_W-1:0] data_q;

   // Storage element with write enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       data_q <= '0;
      else if (we_i) data_q <= d_i;
   end

   assign q_o = data_q;

endmodule

// File: rtl/bus_reg_bank.sv
// Register bank on the byte bus. One command at a time moves a byte through
// the bus latch: IDLE accepts, FETCH fills the latch, WRITE drains it into a
// register (LOAD/MOVE) or onto ext_out (STORE). ADDR_W is expected to be
// clog2(NREG); out-of-range indices read 0 and drop writes.
module bus_reg_bank
   import bus_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREG   = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [DATA_W-1:0] ext_in,
   output logic [DATA_W-1:0] ext_out,
   output logic              ext_out_valid,
   output logic [DATA_W-1:0] bus_val,
   output logic              busy
);

   state_e              state_q, state_d;
   op_e                 op_q;
   logic [ADDR_W-1:0]   src_q, dst_q;
   logic [DATA_W-1:0]   bus_q, bus_d;
   logic [DATA_W-1:0]   ext_out_q, ext_out_d;
   logic                ext_vld_q, ext_vld_d;
   logic                cmd_take;
   logic                wr_en;
   logic [NREG-1:0]     we;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   reg_q [NREG];

   // Next-state and datapath control for the three-step transfer.
   always_comb begin
      state_d   = state_q;
      cmd_take  = 1'b0;
      bus_d     = bus_q;
      ext_out_d = ext_out_q;
      ext_vld_d = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            // NOP is consumed here without leaving IDLE.
            if (cmd_valid && (op_e'(cmd_op) != OP_NOP)) begin
               cmd_take = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: begin
            bus_d   = (op_q == OP_LOAD) ? ext_in : rd_data;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            state_d = S_IDLE;
            if (op_q == OP_STORE) begin
               ext_out_d = bus_q;
               ext_vld_d = 1'b1;
            end else if (op_q == OP_LOAD || op_q == OP_MOVE) begin
               wr_en = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, command latch, bus latch and external output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= OP_NOP;
         src_q     <= '0;
         dst_q     <= '0;
         bus_q     <= '0;
         ext_out_q <= '0;
         ext_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bus_q     <= bus_d;
         ext_out_q <= ext_out_d;
         ext_vld_q <= ext_vld_d;
         if (cmd_take) begin
            op_q  <= op_e'(cmd_op);
            src_q <= cmd_src;
            dst_q <= cmd_dst;
         end
      end
   end

   // Register array; each copy is enabled only when WRITE targets it.
   for (genvar i = 0; i < NREG; i++) begin : g_reg
      assign we[i] = wr_en && (int'(dst_q) == i);
      bus_reg8 #(.DATA_W(DATA_W)) u_reg (
         .clk  (clk),
         .rst  (rst),
         .we_i (we[i]),
         .d_i  (bus_q),
         .q_o  (reg_q[i])
      );
   end

   // Read mux: an index with no matching register yields 0.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NREG; i++) begin
         if (int'(src_q) == i) rd_data = reg_q[i];
      end
   end

   assign cmd_ready     = (state_q == S_IDLE);
   assign busy          = ~cmd_ready;
   assign bus_val       = bus_q;
   assign ext_out       = ext_out_q;
   assign ext_out_valid = ext_vld_q;

endmodule
